// File: rtl/xnor_stimulus_checker.sv
// xnor_stimulus_checker
//   Initiator for a NOR-built XNOR cell (or any WIDTH-wide bit-cell computing
//   ~(a^b)). On a start pulse it sweeps every {a_out,b_out} combination. Each
//   vector is held for SETTLE_CYCLES cycles and then sampled once. Any vector
//   whose response differs from ~(a^b) in at least one bit adds one to
//   err_count. A single done pulse ends the sweep, and pass reports a clean
//   sweep.
//
// Parameters
//   WIDTH          operand width in bits (>= 1)
//   SETTLE_CYCLES  cycles each vector is held before it is sampled (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset; aborts a sweep in progress
//   start      launches a sweep when the block is idle; otherwise ignored
//   busy       high while vectors are being driven or sampled
//   done       one-cycle pulse at the end of a sweep
//   a_out      operand A to the cell under test (upper half of vector_idx)
//   b_out      operand B to the cell under test (lower half of vector_idx)
//   dut_z      response of the cell under test
//   vector_idx index of the current vector (the last vector once finished)
//   err_count  number of mismatching vectors
//   pass       err_count==0, captured at the end of a sweep
//
// Configuration
//   XNOR_CHK_STOP_ON_ERR_EN  when defined, the first mismatching vector ends
//   the sweep. vector_idx, a_out and b_out keep the failing vector.

module xnor_stimulus_checker #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic [WIDTH-1:0]   dut_z,
  output logic [2*WIDTH-1:0] vector_idx,
  output logic [2*WIDTH:0]   err_count,
  output logic               pass
);

  localparam int VW    = 2 * WIDTH;
  localparam int CW    = 2 * WIDTH + 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [VW-1:0]    LAST_IDX    = {VW{1'b1}};
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] settle_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [VW-1:0]    idx_r;
  logic [CW-1:0]    err_r;
  logic             pass_r;

  logic             mismatch_s;
  logic [CW-1:0]    err_next_s;
  logic [VW-1:0]    idx_next_s;
  logic             stop_s;

  // Vector-level check: any differing bit makes the whole vector a mismatch.
  function automatic logic xnor_mismatch(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic [WIDTH-1:0] z);
    return |(z ^ ~(a ^ b));
  endfunction

  // Sample-cycle helpers: mismatch flag, next error count, next index, end of sweep.
  always_comb begin
    mismatch_s = xnor_mismatch(a_r, b_r, dut_z);
    if (mismatch_s) begin
      err_next_s = err_r + CW'(1);
    end else begin
      err_next_s = err_r;
    end
    idx_next_s = idx_r + VW'(1);
`ifdef XNOR_CHK_STOP_ON_ERR_EN
    stop_s = (idx_r == LAST_IDX) || mismatch_s;
`else
    stop_s = (idx_r == LAST_IDX);
`endif
  end

  // Sweep controller: state, settle counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      settle_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      idx_r    <= '0;
      err_r    <= '0;
      pass_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            idx_r    <= '0;
            err_r    <= '0;
            pass_r   <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            settle_r <= SETTLE_LOAD;
            busy_r   <= 1'b1;
            state_r  <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          // The load value is SETTLE_CYCLES-1, so reaching 0 marks the last hold cycle.
          if (settle_r == '0) begin
            state_r <= ST_SAMPLE;
          end else begin
            settle_r <= settle_r - CNT_W'(1);
          end
        end
        ST_SAMPLE: begin
          err_r <= err_next_s;
          if (stop_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (err_next_s == '0);
            state_r <= ST_DONE;
          end else begin
            idx_r      <= idx_next_s;
            {a_r, b_r} <= idx_next_s;
            settle_r   <= SETTLE_LOAD;
            state_r    <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign a_out      = a_r;
  assign b_out      = b_r;
  assign vector_idx = idx_r;
  assign err_count  = err_r;
  assign pass       = pass_r;

endmodule
